// File: rtl/dmem_io_responder.sv
// Data memory with combinational-read RAM, a read-only status word and a byte TX FIFO device.
// Latency: loads are combinational; stores and FIFO pushes take effect on the next rising edge.
// Backpressure: io_tx_valid/io_tx_ready handshake; full-FIFO pushes drop and set sticky overflow. Optional drain IRQ: DMEM_TX_IRQ_EN.
module dmem_io_responder #(
    parameter int         DEPTH_WORDS      = 256,
    parameter int         FIFO_DEPTH       = 8,
    parameter int         STATUS_WORD_ADDR = 509,
    parameter logic [4:0] TX_IRQ_ID        = 5'd3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_write_en,
    input  logic [2:0]  cpu_read_type,
    input  logic        cpu_device_id,
    output logic [31:0] cpu_read_data,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    output logic        io_interrupt,
    output logic [4:0]  io_interrupt_id
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [7:0]    txq [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          in_range;
    logic          is_status;
    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic [31:0]   raw_word;
    logic [31:0]   ext_word;
    logic [3:0]    lane_en;
    logic          dev_store;
    logic          push_req;
    logic          ovf_clr;
    logic          pop;
    logic          push_ok;

    assign in_range  = cpu_addr < 32'(DEPTH_WORDS);
    assign is_status = cpu_addr == 32'(STATUS_WORD_ADDR);
    assign ram_hit   = in_range && !is_status;
    assign ram_idx   = cpu_addr[AW-1:0];

    // Status word is assembled before size/sign processing so narrow loads see its low bytes.
    always_comb begin
        raw_word = 32'd0;
        if (is_status) begin
            raw_word = {overflow, 26'd0, 5'(count)};
        end else if (ram_hit) begin
            raw_word = ram[ram_idx];
        end
        case (cpu_read_type)
            3'b000:  ext_word = {{24{raw_word[7]}}, raw_word[7:0]};
            3'b001:  ext_word = {{16{raw_word[15]}}, raw_word[15:0]};
            3'b100:  ext_word = {24'd0, raw_word[7:0]};
            3'b101:  ext_word = {16'd0, raw_word[15:0]};
            default: ext_word = raw_word;
        endcase
    end

    assign cpu_read_data = reset ? ext_word : 32'd0;

    always_comb begin
        case (cpu_read_type)
            3'b000:  lane_en = 4'b0001;
            3'b001:  lane_en = 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset && cpu_write_en && !cpu_device_id && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    ram[ram_idx][8*i +: 8] <= cpu_write_data[8*i +: 8];
                end
            end
        end
    end

    assign dev_store = reset && cpu_write_en && cpu_device_id;
    assign push_req  = dev_store && !cpu_write_data[31];
    assign ovf_clr   = dev_store && cpu_write_data[31];
    assign pop       = io_tx_valid && io_tx_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok   = push_req && ((count != FULL_CNT) || pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) txq[wr_ptr] <= cpu_write_data[7:0];
    end

    assign io_tx_valid = reset && (count != '0);
    assign io_tx_data  = io_tx_valid ? txq[rd_ptr] : 8'd0;

`ifdef DMEM_TX_IRQ_EN
    logic irq_q;
    logic drain;

    assign drain = pop && !push_ok && (count == CW'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= drain;
        end
    end

    assign io_interrupt    = irq_q;
    assign io_interrupt_id = irq_q ? TX_IRQ_ID : 5'd0;
`else
    assign io_interrupt    = 1'b0;
    assign io_interrupt_id = TX_IRQ_ID & 5'd0;
`endif
endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed and randomized checks of dmem_io_responder against a queue/array reference model.
module tb_dmem_io_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic        cpu_write_en;
    logic [2:0]  cpu_read_type;
    logic        cpu_device_id;
    logic [31:0] cpu_read_data;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready;
    logic        io_interrupt;
    logic [4:0]  io_interrupt_id;

    dmem_io_responder dut (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
        .cpu_write_en(cpu_write_en), .cpu_read_type(cpu_read_type), .cpu_device_id(cpu_device_id),
        .cpu_read_data(cpu_read_data), .io_tx_data(io_tx_data), .io_tx_valid(io_tx_valid),
        .io_tx_ready(io_tx_ready), .io_interrupt(io_interrupt), .io_interrupt_id(io_interrupt_id)
    );

    always #5 clock = ~clock;

`ifdef DMEM_TX_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic [31:0] m_ram [256];
    logic [7:0]  q [$];
    bit          m_ovf;
    bit          m_irq;
    int          n_cmp = 0;
    int          n_mis = 0;

    logic [2:0]  t_tab [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
    logic [31:0] e_tab [5] = '{32'h0000_0034, 32'h0000_1234, 32'h0000_0034, 32'h0000_1234, 32'h80FF_1234};

    function automatic logic [31:0] exp_read(logic [31:0] a, logic [2:0] t);
        logic [31:0] raw;
        if (!reset) return 32'd0;
        if (a == 32'd509)     raw = {m_ovf, 26'd0, 5'(q.size())};
        else if (a < 32'd256) raw = m_ram[a[7:0]];
        else                  raw = 32'd0;
        case (t)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'd0, raw[7:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Next state of the model from the inputs presented for the coming edge.
    task automatic model_edge();
        int n;
        int nl;
        bit pop;
        bit push;
        if (!reset) begin
            q.delete();
            m_ovf = 0;
            m_irq = 0;
            return;
        end
        n    = q.size();
        pop  = (n > 0) && io_tx_ready;
        push = cpu_write_en && cpu_device_id && !cpu_write_data[31];
        m_irq = IRQ_ON && pop && (n == 1) && !push;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (n < 8 || pop) q.push_back(cpu_write_data[7:0]);
            else m_ovf = 1;
        end
        if (cpu_write_en && cpu_device_id && cpu_write_data[31]) m_ovf = 0;
        if (cpu_write_en && !cpu_device_id && cpu_addr < 32'd256) begin
            nl = (cpu_read_type == 3'b000) ? 1 : (cpu_read_type == 3'b001) ? 2 : 4;
            for (int i = 0; i < nl; i++) m_ram[cpu_addr[7:0]][8*i +: 8] = cpu_write_data[8*i +: 8];
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [31:0] a, logic [31:0] wd, logic we, logic [2:0] t, logic dev);
        cpu_addr       = a;
        cpu_write_data = wd;
        cpu_write_en   = we;
        cpu_read_type  = t;
        cpu_device_id  = dev;
        #1;
    endtask

    task automatic store(logic [31:0] a, logic [31:0] wd, logic [2:0] t, logic dev);
        drive(a, wd, 1'b1, t, dev);
        cyc();
        drive(a, 32'd0, 1'b0, 3'b010, 1'b0);
    endtask

    task automatic rd(string tag, logic [31:0] a, logic [2:0] t, logic [31:0] exp);
        drive(a, 32'd0, 1'b0, t, 1'b0);
        chk(tag, cpu_read_data, exp);
    endtask

    task automatic chk_model(string tag);
        bit ev;
        ev = reset && (q.size() > 0);
        chk({tag, "_rdata"}, cpu_read_data, exp_read(cpu_addr, cpu_read_type));
        chk({tag, "_valid"}, 32'(io_tx_valid), 32'(ev));
        if (ev)          chk({tag, "_txdata"}, 32'(io_tx_data), 32'(q[0]));
        else if (!reset) chk({tag, "_txdata_rst"}, 32'(io_tx_data), 32'd0);
        chk({tag, "_irq"}, 32'(io_interrupt), 32'(m_irq));
        chk({tag, "_irqid"}, 32'(io_interrupt_id), m_irq ? 32'd3 : 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int k;
        reset = 1'b0;
        io_tx_ready = 1'b0;
        drive(32'd509, 32'd0, 1'b0, 3'b010, 1'b0);
        repeat (2) cyc();
        chk("rst_rdata", cpu_read_data, 32'd0);
        chk("rst_valid", 32'(io_tx_valid), 32'd0);
        chk("rst_txdata", 32'(io_tx_data), 32'd0);
        chk("rst_irq", 32'(io_interrupt), 32'd0);
        chk("rst_irqid", 32'(io_interrupt_id), 32'd0);
        store(32'd0, 32'h55, 3'b010, 1'b1);
        reset = 1'b1;
        rd("rst_push_suppressed", 32'd509, 3'b010, 32'd0);

        store(32'd10, 32'h80FF_1234, 3'b010, 1'b0);
        for (int i = 0; i < 5; i++) rd("ld_size", 32'd10, t_tab[i], e_tab[i]);
        rd("ld_other_code", 32'd10, 3'b111, 32'h80FF_1234);
        store(32'd11, 32'h0000_80F0, 3'b010, 1'b0);
        rd("ld_sb_neg", 32'd11, 3'b000, 32'hFFFF_FFF0);
        rd("ld_sh_neg", 32'd11, 3'b001, 32'hFFFF_80F0);

        store(32'd10, 32'hAAAA_AAAA, 3'b010, 1'b0);
        store(32'd10, 32'h1122_3344, 3'b000, 1'b0);
        rd("st_byte", 32'd10, 3'b010, 32'hAAAA_AA44);
        store(32'd10, 32'h9988_7766, 3'b001, 1'b0);
        rd("st_half", 32'd10, 3'b010, 32'hAAAA_7766);
        store(32'd300, 32'hDEAD_BEEF, 3'b010, 1'b0);
        rd("oor_read", 32'd300, 3'b010, 32'd0);
        store(32'd509, 32'hFFFF_FFFF, 3'b010, 1'b0);
        rd("status_ro", 32'd509, 3'b010, 32'd0);

        drive(32'd0, 32'h41, 1'b1, 3'b010, 1'b1);
        chk("no_bypass", 32'(io_tx_valid), 32'd0);
        cyc();
        drive(32'd509, 32'd0, 1'b0, 3'b010, 1'b0);
        chk("valid_after_push", 32'(io_tx_valid), 32'd1);
        store(32'd0, 32'h42, 3'b010, 1'b1);
        store(32'd0, 32'h43, 3'b010, 1'b1);
        rd("status_3", 32'd509, 3'b010, 32'h0000_0003);
        chk("head_41", 32'(io_tx_data), 32'h41);
        io_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pop_order", 32'(io_tx_data), 32'h41 + i);
            cyc();
        end
        chk("drained_valid", 32'(io_tx_valid), 32'd0);
        chk("drain_irq", 32'(io_interrupt), 32'(IRQ_ON));
        chk("drain_irqid", 32'(io_interrupt_id), IRQ_ON ? 32'd3 : 32'd0);
        cyc();
        chk("irq_one_cycle", 32'(io_interrupt), 32'd0);
        io_tx_ready = 1'b0;

        for (int i = 0; i < 9; i++) store(32'd0, 32'h60 + i, 3'b010, 1'b1);
        rd("status_ovf", 32'd509, 3'b010, 32'h8000_0008);
        store(32'd0, 32'h8000_0000, 3'b010, 1'b1);
        rd("status_clr", 32'd509, 3'b010, 32'h0000_0008);
        chk("head_60", 32'(io_tx_data), 32'h60);

        io_tx_ready = 1'b1;
        store(32'd0, 32'h70, 3'b010, 1'b1);
        io_tx_ready = 1'b0;
        rd("full_pushpop", 32'd509, 3'b010, 32'h0000_0008);
        chk("head_61", 32'(io_tx_data), 32'h61);
        io_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("full_order", 32'(io_tx_data), (i < 7) ? 32'h61 + i : 32'h70);
            cyc();
        end
        chk_model("after_full");
        io_tx_ready = 1'b0;

        store(32'd0, 32'h21, 3'b010, 1'b1);
        store(32'd0, 32'h22, 3'b010, 1'b1);
        rd("status_2", 32'd509, 3'b010, 32'h0000_0002);
        reset = 1'b0;
        io_tx_ready = 1'b1;
        cyc();
        reset = 1'b1;
        io_tx_ready = 1'b0;
        rd("rst_mid_count", 32'd509, 3'b010, 32'd0);
        chk("rst_mid_valid", 32'(io_tx_valid), 32'd0);
        chk("rst_mid_irq", 32'(io_interrupt), 32'd0);
        cyc();
        chk("rst_mid_irq2", 32'(io_interrupt), 32'd0);

        for (int i = 0; i < 16; i++) store(i, $urandom, 3'b010, 1'b0);
        for (int c = 0; c < 800; c++) begin
            k = $urandom_range(0, 19);
            if (k < 16)       a = 32'(k);
            else if (k == 16) a = 32'd300;
            else if (k == 17) a = 32'd509;
            else if (k == 18) a = 32'd256;
            else              a = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
            reset = ($urandom_range(0, 63) != 0);
            io_tx_ready = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, 15);
            if (k < 5)       drive(a, $urandom, 1'b1, 3'($urandom_range(0, 7)), 1'b0);
            else if (k < 10) drive(a, {1'b0, 31'($urandom)}, 1'b1, 3'($urandom_range(0, 7)), 1'b1);
            else if (k == 10) drive(a, 32'h8000_0000 | $urandom, 1'b1, 3'b010, 1'b1);
            else             drive(a, $urandom, 1'b0, 3'($urandom_range(0, 7)), 1'b0);
            chk_model("rnd");
            cyc();
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
